sram_counter_ctrl: RTL and testbench
====================================

# sram_counter_ctrl

Controller that maintains N independent DW-bit event counters in an external `dpsram` instance. It accepts increment and read-back requests on valid/ready interfaces and drives the SRAM read port (port 0) and write port (port 1) as a two-stage read-modify-write pipeline. Forwarding keeps back-to-back operations on the same counter correct. After reset it zeroes all N entries before accepting requests. Both SRAM clocks are tied to `clk` at the parent.

## Interface
- `N`, 16, number of counters (SRAM depth)
- `DW`, 32, counter width (SRAM data width)
- `AW`, `$clog2(N)`, counter index width
- `clk`  in  1  single clock, rising edge; drives the block and both SRAM ports
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `inc_valid`  in  1  increment request
- `inc_ready`  out  1  increment accepted when `inc_valid && inc_ready`
- `inc_id`  in  AW  counter to increment
- `rd_valid`  in  1  read-back request
- `rd_ready`  out  1  read accepted when `rd_valid && rd_ready`
- `rd_id`  in  AW  counter to read
- `rd_data_valid`  out  1  `rd_data` valid, single-cycle pulse
- `rd_data`  out  DW  counter value
- `init_done`  out  1  high once zeroing is complete
- `mem_en0`, `mem_wen0`, `mem_addr0`[AW], `mem_din0`[DW]  out  SRAM port 0 controls; `mem_wen0` and `mem_din0` are tied to 0
- `mem_dout0`  in  DW  SRAM port 0 read data, registered inside the SRAM
- `mem_en1`, `mem_wen1`, `mem_addr1`[AW], `mem_din1`[DW]  out  SRAM port 1 (write-only)

## Operation
- FSM states: INIT and RUN. Reset sets INIT with sweep index 0.
- INIT:
  - Each cycle drive `mem_en1=1`, `mem_wen1=1`, `mem_addr1=idx`, `mem_din1=0`, then `idx++`.
  - Writing `idx==N-1` moves the FSM to RUN.
  - Writes issued while `rst_n` is low are harmless zero writes.
  - `inc_ready=0`, `rd_ready=0` throughout INIT.
- RUN:
  - `rd_ready=1`.
  - `inc_ready = !rd_valid`. Reads have priority; at most one operation is accepted per cycle.
- Stage 0 (accept cycle): combinationally drive `mem_en0=1`, `mem_addr0` = accepted id. No accept means `mem_en0=0`.
- Stage 1 (next cycle): register `s1_valid`, `s1_op` (INC/RD), `s1_id`.
  - `base` = `fwd_data` if (`fwd_valid && fwd_id==s1_id`), otherwise `mem_dout0`.
  - INC: drive `mem_en1=1`, `mem_wen1=1`, `mem_addr1=s1_id`, `mem_din1=base+1`. The sum is truncated to DW bits, so the counter wraps from 2^DW-1 to 0.
  - RD: `rd_data=base` and `rd_data_valid=1`, both combinational from stage 1. No write.
- Forward register: at every edge, `fwd_valid` ← (`s1_valid && s1_op==INC`), `fwd_id` ← `s1_id`, `fwd_data` ← `base+1`.
  - This covers the single write that is not yet visible to a read latched on the same edge as the write.
  - One-deep forwarding is sufficient.
- Outside INIT and stage-1 INC, port 1 is idle: `mem_en1=0`, `mem_wen1=0`, `mem_addr1=0`, `mem_din1=0`.

## Timing
- Reset values (while `rst_n` low):
  - State INIT: `inc_ready=0`, `rd_ready=0`, `rd_data_valid=0`, `rd_data=0`, `init_done=0`.
  - SRAM port 0: `mem_en0=0`, `mem_addr0=0`, `mem_wen0=0`, `mem_din0=0`.
  - SRAM port 1: `mem_en1=1`, `mem_wen1=1`, `mem_addr1=0`, `mem_din1=0`.
  - Internal: `s1_valid=0`, `fwd_valid=0`.
- Init takes exactly N cycles after `rst_n` rises. `init_done`, `inc_ready` and `rd_ready` go high on cycle N, counting the first post-reset cycle as 0.
- Throughput is one operation per cycle, sustained, for any mix of ids.
- Read latency: accepted at edge E, `rd_data_valid` is high in the cycle after E.
- Increment visibility:
  - Increment accepted at E writes SRAM at E+1.
  - A read or increment of the same id accepted at E+1 sees the new value via forwarding.
  - Accepted at E+2 or later, it sees the new value via the SRAM.
- `rd_valid` and `inc_valid` in the same cycle: the read is accepted, the increment stalls, and `inc_id` must be held by the requester.
- Reset asserted mid-operation: in-flight stage-1 ops are dropped and no `rd_data_valid` pulse is produced. Re-init zeroes all counters.
- Requesters may not drop `*_valid` or change `*_id` while ready is low.

## Test plan
- **Init:** release reset with N=16 → exactly 16 port-1 zero writes (addr 0..15) on consecutive cycles, then `init_done=1`. Reading every id returns 0.
- **Single increment:** inc id 3 once, then read id 3 two cycles later → `rd_data=1`, `rd_data_valid` high for one cycle.
- **Back-to-back same id:** inc id 5 on 4 consecutive cycles, then read id 5 in the next cycle → 4 (exercises forwarding). Read again 3 cycles later → 4.
- **Interleaved ids and priority:** alternate inc 1 / inc 2 for 10 cycles with `rd_valid`, `rd_id=1` asserted on cycle 4 → `inc_ready=0` in that cycle, read returns 2. Final values are id1=5, id2=5.
- **Wrap:** DW=4, inc id 0 seventeen times → read returns 1.
- **Reset mid-stream:** assert `rst_n=0` with a read in stage 1 → no `rd_data_valid` pulse. After re-init, all ids read 0.

Source files
------------

// File: rtl/sram_counter_ctrl_if.sv
// Request/response bus between a counter client and sram_counter_ctrl.
// The client (master) issues increment and read-back requests; the
// controller (slave) grants them and returns read data one cycle later.
interface sram_counter_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 32
);
  logic          inc_valid;
  logic          inc_ready;
  logic [AW-1:0] inc_id;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_id;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;

  modport master (
    output inc_valid, inc_id, rd_valid, rd_id,
    input  inc_ready, rd_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  inc_valid, inc_id, rd_valid, rd_id,
    output inc_ready, rd_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/sram_counter_ctrl.sv
// Keeps N event counters in an external dual-port SRAM. Port 0 reads,
// port 1 writes; each operation is a two-stage read-modify-write with a
// one-deep forward register covering the write that lands on the same
// edge as a following read of the same counter. All entries are zeroed
// after reset before any request is granted.
module sram_counter_ctrl #(
  parameter int N  = 16,
  parameter int DW = 32,
  parameter int AW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_counter_ctrl_if.slave  bus,
  output logic                init_done,
  output logic                mem_en0,
  output logic                mem_wen0,
  output logic [AW-1:0]       mem_addr0,
  output logic [DW-1:0]       mem_din0,
  input  logic [DW-1:0]       mem_dout0,
  output logic                mem_en1,
  output logic                mem_wen1,
  output logic [AW-1:0]       mem_addr1,
  output logic [DW-1:0]       mem_din1
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {OP_INC, OP_RD} op_t;

  state_t        state;
  logic [AW-1:0] idx;

  logic          acc_rd;
  logic          acc_inc;

  logic          s1_valid;
  op_t           s1_op;
  logic [AW-1:0] s1_id;

  logic          fwd_valid;
  logic [AW-1:0] fwd_id;
  logic [DW-1:0] fwd_data;

  logic [DW-1:0] base;
  logic [DW-1:0] base_inc;

  // Zeroing sweep after reset, then switch to normal operation for good.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      idx       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (idx == AW'(N - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RUN: begin
          state     <= RUN;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Reads win over increments so at most one operation enters per cycle.
  assign bus.rd_ready  = init_done;
  assign bus.inc_ready = init_done && !bus.rd_valid;
  assign acc_rd        = init_done && bus.rd_valid;
  assign acc_inc       = init_done && bus.inc_valid && !bus.rd_valid;

  // Stage 0: launch the SRAM read for whichever request is accepted.
  always_comb begin
    mem_en0   = acc_rd || acc_inc;
    mem_addr0 = '0;
    if (acc_rd) begin
      mem_addr0 = bus.rd_id;
    end else if (acc_inc) begin
      mem_addr0 = bus.inc_id;
    end
  end

  assign mem_wen0 = 1'b0;
  assign mem_din0 = '0;

  // Latest counter value: the forward register beats SRAM data that is one write stale.
  assign base     = (fwd_valid && (fwd_id == s1_id)) ? fwd_data : mem_dout0;
  assign base_inc = base + DW'(1);

  // Stage 1 registers and the forward register; a reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_INC;
      s1_id     <= '0;
      fwd_valid <= 1'b0;
      fwd_id    <= '0;
      fwd_data  <= '0;
    end else begin
      s1_valid  <= acc_rd || acc_inc;
      s1_op     <= acc_rd ? OP_RD : OP_INC;
      s1_id     <= mem_addr0;
      fwd_valid <= s1_valid && (s1_op == OP_INC);
      fwd_id    <= s1_id;
      fwd_data  <= base_inc;
    end
  end

  // Port 1 writes zeros during the sweep and incremented values afterwards; read data comes straight from stage 1.
  always_comb begin
    mem_en1           = 1'b0;
    mem_wen1          = 1'b0;
    mem_addr1         = '0;
    mem_din1          = '0;
    bus.rd_data_valid = 1'b0;
    bus.rd_data       = '0;
    if (state == INIT) begin
      mem_en1   = 1'b1;
      mem_wen1  = 1'b1;
      mem_addr1 = idx;
    end else if (s1_valid && (s1_op == OP_INC)) begin
      mem_en1   = 1'b1;
      mem_wen1  = 1'b1;
      mem_addr1 = s1_id;
      mem_din1  = base_inc;
    end else if (s1_valid && (s1_op == OP_RD)) begin
      bus.rd_data_valid = 1'b1;
      bus.rd_data       = base;
    end
  end

endmodule

// File: tb/tb_sram_counter_ctrl.sv
// Bench for sram_counter_ctrl: a 16x32 instance checked by directed
// vectors, a per-cycle reference model and random traffic, plus a 4x4
// instance used to see the counter wrap.
module tb_sram_counter_ctrl;

  localparam int N = 16;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  sram_counter_ctrl_if #(.AW(4), .DW(32)) bus_a ();
  sram_counter_ctrl_if #(.AW(2), .DW(4))  bus_b ();

  logic        init_done_a, mem_en0_a, mem_wen0_a, mem_en1_a, mem_wen1_a;
  logic [3:0]  mem_addr0_a, mem_addr1_a;
  logic [31:0] mem_din0_a, mem_dout0_a, mem_din1_a;
  logic [31:0] sram_a [16];

  logic        init_done_b, mem_en0_b, mem_wen0_b, mem_en1_b, mem_wen1_b;
  logic [1:0]  mem_addr0_b, mem_addr1_b;
  logic [3:0]  mem_din0_b, mem_dout0_b, mem_din1_b;
  logic [3:0]  sram_b [4];

  sram_counter_ctrl #(.N(16), .DW(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .init_done(init_done_a),
    .mem_en0(mem_en0_a), .mem_wen0(mem_wen0_a), .mem_addr0(mem_addr0_a),
    .mem_din0(mem_din0_a), .mem_dout0(mem_dout0_a),
    .mem_en1(mem_en1_a), .mem_wen1(mem_wen1_a), .mem_addr1(mem_addr1_a),
    .mem_din1(mem_din1_a)
  );

  sram_counter_ctrl #(.N(4), .DW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .init_done(init_done_b),
    .mem_en0(mem_en0_b), .mem_wen0(mem_wen0_b), .mem_addr0(mem_addr0_b),
    .mem_din0(mem_din0_b), .mem_dout0(mem_dout0_b),
    .mem_en1(mem_en1_b), .mem_wen1(mem_wen1_b), .mem_addr1(mem_addr1_b),
    .mem_din1(mem_din1_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Read-first dual-port SRAM behind the large instance.
  always @(posedge clk) begin
    if (mem_en0_a) mem_dout0_a <= sram_a[mem_addr0_a];
    if (mem_en1_a && mem_wen1_a) sram_a[mem_addr1_a] = mem_din1_a;
  end

  // Read-first dual-port SRAM behind the wrap instance.
  always @(posedge clk) begin
    if (mem_en0_b) mem_dout0_b <= sram_b[mem_addr0_b];
    if (mem_en1_b && mem_wen1_b) sram_b[mem_addr1_b] = mem_din1_b;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [3:0] iid, input logic rv, input logic [3:0] rid);
    bus_a.inc_valid = iv;
    bus_a.inc_id    = iid;
    bus_a.rd_valid  = rv;
    bus_a.rd_id     = rid;
  endtask

  // Reference model: counters as plain integers, updated when a request is
  // granted; every read must return the count seen at its grant, one cycle later.
  logic [31:0] model [16];
  int          cyc;
  logic        pend;
  logic [31:0] pend_val;
  logic        run_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("rst_dv", 32'(bus_a.rd_data_valid), 32'd0);
      pend = 1'b0;
      cyc  = 0;
      for (int i = 0; i < N; i++) model[i] = 32'd0;
    end else begin
      run_exp = (cyc >= N);
      check_output("init_done", 32'(init_done_a), 32'(run_exp));
      check_output("rd_ready", 32'(bus_a.rd_ready), 32'(run_exp));
      check_output("inc_ready", 32'(bus_a.inc_ready), 32'(run_exp && !bus_a.rd_valid));
      if (!run_exp) begin
        check_output("init_wr_en", 32'(mem_en1_a && mem_wen1_a), 32'd1);
        check_output("init_wr_addr", 32'(mem_addr1_a), 32'(cyc));
        check_output("init_wr_data", mem_din1_a, 32'd0);
      end
      check_output("rd_dv", 32'(bus_a.rd_data_valid), 32'(pend));
      if (pend) check_output("rd_data_model", bus_a.rd_data, pend_val);
      pend = 1'b0;
      if (run_exp && bus_a.rd_valid) begin
        pend     = 1'b1;
        pend_val = model[bus_a.rd_id];
      end else if (run_exp && bus_a.inc_valid) begin
        model[bus_a.inc_id] = model[bus_a.inc_id] + 32'd1;
      end
      if (cyc < 1000) cyc++;
    end
  end

  typedef struct {
    logic        inc_v;
    logic [3:0]  inc_id;
    logic        rd_v;
    logic [3:0]  rd_id;
    logic        exp_inc_ready;
    logic        exp_dv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic iv, input logic [3:0] iid, input logic rv, input logic [3:0] rid,
                         input logic eir, input logic edv, input logic [31:0] ed);
    vec_t v;
    v.inc_v = iv; v.inc_id = iid; v.rd_v = rv; v.rd_id = rid;
    v.exp_inc_ready = eir; v.exp_dv = edv; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic read_sweep();
    for (int i = 0; i < N; i++) begin
      apply_stimulus(1'b0, 4'd0, 1'b1, 4'(i));
      @(posedge clk); #1;
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
    @(posedge clk); #1;
  endtask

  logic hold;

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus_b.inc_valid = 1'b0; bus_b.inc_id = 2'd0;
    bus_b.rd_valid  = 1'b0; bus_b.rd_id  = 2'd0;
    for (int i = 0; i < 16; i++) sram_a[i] = $urandom;
    for (int i = 0; i < 4; i++)  sram_b[i] = 4'($urandom);

    // single increment, then read two cycles later
    add_vec(1, 3, 0, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 3, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 1);
    // four back-to-back increments of id 5, read next cycle and again later
    for (int i = 0; i < 4; i++) add_vec(1, 5, 0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 5, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 4);
    add_vec(0, 0, 0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 5, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 4);
    // alternating ids 1/2 with a read of id 1 stalling the increment
    add_vec(1, 1, 0, 0, 1, 0, 0);
    add_vec(1, 2, 0, 0, 1, 0, 0);
    add_vec(1, 1, 0, 0, 1, 0, 0);
    add_vec(1, 2, 0, 0, 1, 0, 0);
    add_vec(1, 1, 1, 1, 0, 0, 0);
    add_vec(1, 1, 0, 0, 1, 1, 2);
    add_vec(1, 2, 0, 0, 1, 0, 0);
    add_vec(1, 1, 0, 0, 1, 0, 0);
    add_vec(1, 2, 0, 0, 1, 0, 0);
    add_vec(1, 1, 0, 0, 1, 0, 0);
    add_vec(1, 2, 0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 1, 0, 0, 0);
    add_vec(0, 0, 1, 2, 0, 1, 5);
    add_vec(0, 0, 0, 0, 1, 1, 5);
    // read immediately after an increment of the same id
    add_vec(1, 7, 0, 0, 1, 0, 0);
    add_vec(0, 0, 1, 7, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 1);

    // reset values with requests pending
    apply_stimulus(1'b1, 4'd3, 1'b1, 4'd5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_inc_ready", 32'(bus_a.inc_ready), 32'd0);
    check_output("rst_rd_ready", 32'(bus_a.rd_ready), 32'd0);
    check_output("rst_rd_data", bus_a.rd_data, 32'd0);
    check_output("rst_init_done", 32'(init_done_a), 32'd0);
    check_output("rst_port0", {mem_din0_a[27:0], mem_addr0_a} | 32'(mem_en0_a) | 32'(mem_wen0_a), 32'd0);
    check_output("rst_port1_ctl", 32'({mem_en1_a, mem_wen1_a}), 32'd3);
    check_output("rst_port1_addr", 32'(mem_addr1_a), 32'd0);
    check_output("rst_port1_data", mem_din1_a, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
    repeat (N) @(posedge clk);
    #1;
    read_sweep();

    // directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].inc_v, vecs[i].inc_id, vecs[i].rd_v, vecs[i].rd_id);
      @(negedge clk);
      check_output($sformatf("vec%0d_inc_ready", i), 32'(bus_a.inc_ready), 32'(vecs[i].exp_inc_ready));
      check_output($sformatf("vec%0d_dv", i), 32'(bus_a.rd_data_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) check_output($sformatf("vec%0d_data", i), bus_a.rd_data, vecs[i].exp_data);
      @(posedge clk); #1;
    end

    // random traffic, mostly on a few ids so forwarding is hit often
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        bus_a.inc_valid = 1'($urandom_range(0, 1));
        bus_a.inc_id    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      end
      bus_a.rd_valid = ($urandom_range(0, 3) == 0);
      bus_a.rd_id    = 4'($urandom_range(0, 3));
      @(negedge clk);
      hold = bus_a.inc_valid && !bus_a.inc_ready;
      @(posedge clk); #1;
    end
    apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset while a read sits in stage 1
    apply_stimulus(1'b0, 4'd0, 1'b1, 4'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 4'd0, 1'b0, 4'd0);
    @(negedge clk);
    check_output("reset_drop_dv", 32'(bus_a.rd_data_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (N) @(posedge clk);
    #1;
    read_sweep();

    // wrap on the 4-bit instance: 17 increments of id 0 leave it at 1
    for (int i = 0; i < 17; i++) begin
      bus_b.inc_valid = 1'b1;
      bus_b.inc_id    = 2'd0;
      @(negedge clk);
      check_output("wrap_inc_ready", 32'(bus_b.inc_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus_b.inc_valid = 1'b0;
    bus_b.rd_valid  = 1'b1;
    bus_b.rd_id     = 2'd0;
    @(negedge clk);
    check_output("wrap_dv_early", 32'(bus_b.rd_data_valid), 32'd0);
    @(posedge clk); #1;
    bus_b.rd_valid = 1'b0;
    @(negedge clk);
    check_output("wrap_dv", 32'(bus_b.rd_data_valid), 32'd1);
    check_output("wrap_data", 32'(bus_b.rd_data), 32'd1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
